// File: rtl/prog_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_uart_loader
//  Description : UART 8N1 receiver that streams a program into program RAM.
//  Revision    : 1.0
// ============================================================================
module prog_uart_loader #(
    parameter int         CLKS_PER_BIT = 221,
    parameter int         AW           = 12,
    parameter logic [7:0] END_CHAR     = 8'h04,
    parameter bit         FILTER       = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rx,
    input  logic          start_req,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic          overflow,
    output logic          frame_err,
    output logic          prog_we,
    output logic [AW-1:0] prog_waddr,
    output logic [7:0]    prog_wdata
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]        c_DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]        c_LAST_LEN  = c_DEPTH - 1'b1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        START      = 3'd2,
        DATA       = 3'd3,
        STOP       = 3'd4,
        TERM       = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 pend_q, pend_d;
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW:0]          len_q, len_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 ovf_q, ovf_d, ferr_q, ferr_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [7:0]           wdata_q, wdata_d;

    function automatic logic is_cmd(input logic [7:0] b);
        case (b)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default:                                                 is_cmd = 1'b0;
        endcase
    endfunction

    always_comb begin
        rx_meta_d = uart_rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        pend_d    = 1'b0;
        wptr_d    = wptr_q;
        len_d     = len_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        ferr_d    = ferr_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                // busy_q is still high in the cycle carrying the done pulse
                if (start_req && !busy_q) begin
                    state_d = WAIT_START;
                    wptr_d  = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    ferr_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            WAIT_START: begin
                if (pend_q) begin
                    if (shreg_q == END_CHAR) begin
                        state_d = TERM;
                    end else if (!FILTER || is_cmd(shreg_q)) begin
                        we_d    = 1'b1;
                        waddr_d = wptr_q;
                        wdata_d = shreg_q;
                        wptr_d  = wptr_q + 1'b1;
                        len_d   = len_q + 1'b1;
                        if (len_q == c_LAST_LEN) begin
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                // Start-bit detection shares the evaluation cycle so back-to-back frames survive
                if (state_d == WAIT_START && !rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? WAIT_START : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == c_BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_START;
                    if (rx_s_q) pend_d = 1'b1;
                    else        ferr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TERM: begin
                if (len_q != c_DEPTH) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = 8'h00;
                end
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            pend_q    <= 1'b0;
            wptr_q    <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            pend_q    <= pend_d;
            wptr_q    <= wptr_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign prog_len   = len_q;
    assign overflow   = ovf_q;
    assign frame_err  = ferr_q;
    // A strobe already registered must not reach the RAM in the reset cycle
    assign prog_we    = we_q & ~reset;
    assign prog_waddr = waddr_q;
    assign prog_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_uart_loader
//  Description : Directed self-checking bench for prog_uart_loader.
//  Revision    : 1.0
// ============================================================================
module tb_prog_uart_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_a = 1'b1, rx_b = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        busy_a, done_a, ovf_a, ferr_a, we_a;
    logic [12:0] len_a;
    logic [11:0] waddr_a;
    logic [7:0]  wdata_a;
    logic        busy_b, done_b, ovf_b, ferr_b, we_b;
    logic [3:0]  len_b;
    logic [2:0]  waddr_b;
    logic [7:0]  wdata_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int viol_cnt = 0;
    logic [11:0] log_addr_a[$];
    logic [7:0]  log_data_a[$];
    logic [2:0]  log_addr_b[$];
    logic [7:0]  log_data_b[$];

    always #5 clk = ~clk;

    prog_uart_loader #(.CLKS_PER_BIT(CPB), .AW(12), .END_CHAR(8'h04), .FILTER(1'b1)) dut_a (
        .clk(clk), .reset(reset), .uart_rx(rx_a), .start_req(start_a),
        .busy(busy_a), .done(done_a), .prog_len(len_a), .overflow(ovf_a),
        .frame_err(ferr_a), .prog_we(we_a), .prog_waddr(waddr_a), .prog_wdata(wdata_a)
    );

    prog_uart_loader #(.CLKS_PER_BIT(CPB), .AW(3), .END_CHAR(8'h04), .FILTER(1'b0)) dut_b (
        .clk(clk), .reset(reset), .uart_rx(rx_b), .start_req(start_b),
        .busy(busy_b), .done(done_b), .prog_len(len_b), .overflow(ovf_b),
        .frame_err(ferr_b), .prog_we(we_b), .prog_waddr(waddr_b), .prog_wdata(wdata_b)
    );

    always @(negedge clk) begin
        if (we_a) begin log_addr_a.push_back(waddr_a); log_data_a.push_back(wdata_a); end
        if (we_b) begin log_addr_b.push_back(waddr_b); log_data_b.push_back(wdata_b); end
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if ((we_a && !busy_a) || (we_b && !busy_b)) viol_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input int sel, input logic v, input int cycles);
        if (sel == 0) rx_a = v; else rx_b = v;
        tick(cycles);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
        drive_bit(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i], CPB);
        drive_bit(sel, stop, CPB);
        if (!stop) drive_bit(sel, 1'b1, 2 * CPB);
        else if (sel == 0) rx_a = 1'b1;
        else rx_b = 1'b1;
    endtask

    task automatic arm(input int sel);
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        tick(2);
    endtask

    task automatic clear_logs();
        log_addr_a.delete(); log_data_a.delete();
        log_addr_b.delete(); log_data_b.delete();
    endtask

    task automatic wait_done(input int sel, input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((sel == 0 ? done_cnt_a : done_cnt_b) != d0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        tick(4);
    endtask

    task automatic test_reset();
        tick(5);
        reset = 1'b0;
        tick(2);
        total_cnt++; if (busy_a !== 1'b0)  $display("FAIL rst_busy got %b want 0", busy_a);  else pass_cnt++;
        total_cnt++; if (done_a !== 1'b0)  $display("FAIL rst_done got %b want 0", done_a);  else pass_cnt++;
        total_cnt++; if (we_a !== 1'b0)    $display("FAIL rst_we got %b want 0", we_a);      else pass_cnt++;
        total_cnt++; if (len_a !== 13'd0)  $display("FAIL rst_len got %0d want 0", len_a);   else pass_cnt++;
        total_cnt++; if (ovf_a !== 1'b0)   $display("FAIL rst_ovf got %b want 0", ovf_a);    else pass_cnt++;
        total_cnt++; if (ferr_a !== 1'b0)  $display("FAIL rst_ferr got %b want 0", ferr_a);  else pass_cnt++;
        total_cnt++; if (waddr_a !== 12'd0 || wdata_a !== 8'h00)
            $display("FAIL rst_wport got %02h@%0d want 00@0", wdata_a, waddr_a); else pass_cnt++;
    endtask

    task automatic test_basic_load();
        logic [7:0] bytes [5] = '{8'h2B, 8'h5B, 8'h2D, 8'h5D, 8'h04};
        logic [7:0] exp_d [5] = '{8'h2B, 8'h5B, 8'h2D, 8'h5D, 8'h00};
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_a;
        arm(0);
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL basic_busy got %b want 1", busy_a); else pass_cnt++;
        for (int i = 0; i < 5; i++) send_byte(0, bytes[i], 1'b1);
        wait_done(0, d0, ok);
        total_cnt++; if (!ok) $display("FAIL basic_done_timeout got none want pulse"); else pass_cnt++;
        total_cnt++; if (done_cnt_a !== d0 + 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt_a - d0); else pass_cnt++;
        total_cnt++; if (log_data_a.size() !== 5) $display("FAIL basic_nwrites got %0d want 5", log_data_a.size()); else pass_cnt++;
        for (int i = 0; i < 5 && i < log_data_a.size(); i++) begin
            total_cnt++;
            if (log_addr_a[i] !== 12'(i) || log_data_a[i] !== exp_d[i])
                $display("FAIL basic_wr%0d got %02h@%0d want %02h@%0d", i, log_data_a[i], log_addr_a[i], exp_d[i], i);
            else pass_cnt++;
        end
        total_cnt++; if (len_a !== 13'd4) $display("FAIL basic_len got %0d want 4", len_a); else pass_cnt++;
        total_cnt++; if (ovf_a !== 1'b0)  $display("FAIL basic_ovf got %b want 0", ovf_a);  else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy_a); else pass_cnt++;
    endtask

    task automatic test_filter();
        logic [7:0] bytes [7] = '{8'h61, 8'h2B, 8'h20, 8'h62, 8'h0A, 8'h2E, 8'h04};
        logic [7:0] exp_d [3] = '{8'h2B, 8'h2E, 8'h00};
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_a;
        arm(0);
        for (int i = 0; i < 7; i++) send_byte(0, bytes[i], 1'b1);
        wait_done(0, d0, ok);
        total_cnt++; if (!ok) $display("FAIL filter_done_timeout got none want pulse"); else pass_cnt++;
        total_cnt++; if (log_data_a.size() !== 3) $display("FAIL filter_nwrites got %0d want 3", log_data_a.size()); else pass_cnt++;
        for (int i = 0; i < 3 && i < log_data_a.size(); i++) begin
            total_cnt++;
            if (log_addr_a[i] !== 12'(i) || log_data_a[i] !== exp_d[i])
                $display("FAIL filter_wr%0d got %02h@%0d want %02h@%0d", i, log_data_a[i], log_addr_a[i], exp_d[i], i);
            else pass_cnt++;
        end
        total_cnt++; if (len_a !== 13'd2) $display("FAIL filter_len got %0d want 2", len_a); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_b;
        arm(1);
        for (int i = 0; i < 9; i++) send_byte(1, 8'h3E, 1'b1);
        wait_done(1, d0, ok);
        total_cnt++; if (!ok) $display("FAIL ovf_done_timeout got none want pulse"); else pass_cnt++;
        total_cnt++; if (done_cnt_b !== d0 + 1) $display("FAIL ovf_done_pulses got %0d want 1", done_cnt_b - d0); else pass_cnt++;
        total_cnt++; if (log_data_b.size() !== 8) $display("FAIL ovf_nwrites got %0d want 8", log_data_b.size()); else pass_cnt++;
        for (int i = 0; i < 8 && i < log_data_b.size(); i++) begin
            total_cnt++;
            if (log_addr_b[i] !== 3'(i) || log_data_b[i] !== 8'h3E)
                $display("FAIL ovf_wr%0d got %02h@%0d want 3e@%0d", i, log_data_b[i], log_addr_b[i], i);
            else pass_cnt++;
        end
        total_cnt++; if (ovf_b !== 1'b1)  $display("FAIL ovf_flag got %b want 1", ovf_b);   else pass_cnt++;
        total_cnt++; if (len_b !== 4'd8)  $display("FAIL ovf_len got %0d want 8", len_b);   else pass_cnt++;
        total_cnt++; if (busy_b !== 1'b0) $display("FAIL ovf_busy got %b want 0", busy_b);  else pass_cnt++;
    endtask

    task automatic test_nofilter();
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_b;
        arm(1);
        total_cnt++; if (ovf_b !== 1'b0) $display("FAIL nof_ovf_clear got %b want 0", ovf_b); else pass_cnt++;
        send_byte(1, 8'h61, 1'b1);
        send_byte(1, 8'h04, 1'b1);
        wait_done(1, d0, ok);
        total_cnt++; if (!ok) $display("FAIL nof_done_timeout got none want pulse"); else pass_cnt++;
        total_cnt++;
        if (log_data_b.size() !== 2 || log_data_b[0] !== 8'h61 || log_addr_b[0] !== 3'd0 ||
            log_data_b[1] !== 8'h00 || log_addr_b[1] !== 3'd1)
            $display("FAIL nof_writes got %0d writes want 61@0 00@1", log_data_b.size());
        else pass_cnt++;
        total_cnt++; if (len_b !== 4'd1) $display("FAIL nof_len got %0d want 1", len_b); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_a;
        arm(0);
        send_byte(0, 8'h2B, 1'b0);
        send_byte(0, 8'h2D, 1'b1);
        send_byte(0, 8'h04, 1'b1);
        wait_done(0, d0, ok);
        total_cnt++; if (!ok) $display("FAIL ferr_done_timeout got none want pulse"); else pass_cnt++;
        total_cnt++; if (ferr_a !== 1'b1) $display("FAIL ferr_flag got %b want 1", ferr_a); else pass_cnt++;
        total_cnt++;
        if (log_data_a.size() !== 2 || log_data_a[0] !== 8'h2D || log_addr_a[0] !== 12'd0 ||
            log_data_a[1] !== 8'h00 || log_addr_a[1] !== 12'd1)
            $display("FAIL ferr_writes got %0d writes want 2d@0 00@1", log_data_a.size());
        else pass_cnt++;
        total_cnt++; if (len_a !== 13'd1) $display("FAIL ferr_len got %0d want 1", len_a); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_a;
        arm(0);
        total_cnt++; if (ferr_a !== 1'b0) $display("FAIL glitch_ferr_clear got %b want 0", ferr_a); else pass_cnt++;
        drive_bit(0, 1'b0, CPB / 4);
        drive_bit(0, 1'b1, 3 * CPB);
        total_cnt++; if (log_data_a.size() !== 0) $display("FAIL glitch_nwrites got %0d want 0", log_data_a.size()); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b1) $display("FAIL glitch_busy got %b want 1", busy_a); else pass_cnt++;
        total_cnt++; if (done_cnt_a !== d0) $display("FAIL glitch_done got %0d want 0", done_cnt_a - d0); else pass_cnt++;
        send_byte(0, 8'h04, 1'b1);
        wait_done(0, d0, ok);
        total_cnt++;
        if (!ok || log_data_a.size() !== 1 || log_data_a[0] !== 8'h00 || log_addr_a[0] !== 12'd0)
            $display("FAIL glitch_term got %0d writes done=%0b want 00@0", log_data_a.size(), ok);
        else pass_cnt++;
        total_cnt++; if (len_a !== 13'd0) $display("FAIL glitch_len got %0d want 0", len_a); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'h2B;
        clear_logs();
        arm(0);
        drive_bit(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(0, b[i], CPB);
        drive_bit(0, b[4], CPB / 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy_a); else pass_cnt++;
        total_cnt++; if (we_a !== 1'b0)   $display("FAIL rmid_we got %b want 0", we_a);     else pass_cnt++;
        drive_bit(0, b[4], CPB / 2 - 1);
        for (int i = 5; i < 8; i++) drive_bit(0, b[i], CPB);
        drive_bit(0, 1'b1, 3 * CPB);
        total_cnt++; if (log_data_a.size() !== 0) $display("FAIL rmid_nwrites got %0d want 0", log_data_a.size()); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL rmid_idle got %b want 0", busy_a); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4] = '{8'h2B, 8'h2D, 8'h2E, 8'h00};
        int d0;
        bit ok;
        clear_logs();
        d0 = done_cnt_a;
        arm(0);
        send_byte(0, 8'h2B, 1'b1);
        arm(0);
        send_byte(0, 8'h2D, 1'b1);
        send_byte(0, 8'h2E, 1'b1);
        send_byte(0, 8'h04, 1'b1);
        wait_done(0, d0, ok);
        total_cnt++; if (!ok) $display("FAIL b2b_done_timeout got none want pulse"); else pass_cnt++;
        total_cnt++; if (log_data_a.size() !== 4) $display("FAIL b2b_nwrites got %0d want 4", log_data_a.size()); else pass_cnt++;
        for (int i = 0; i < 4 && i < log_data_a.size(); i++) begin
            total_cnt++;
            if (log_addr_a[i] !== 12'(i) || log_data_a[i] !== exp_d[i])
                $display("FAIL b2b_wr%0d got %02h@%0d want %02h@%0d", i, log_data_a[i], log_addr_a[i], exp_d[i], i);
            else pass_cnt++;
        end
        total_cnt++; if (len_a !== 13'd3) $display("FAIL b2b_len got %0d want 3", len_a); else pass_cnt++;
        total_cnt++; if (viol_cnt !== 0) $display("FAIL we_outside_busy got %0d want 0", viol_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_filter();
        test_overflow();
        test_nofilter();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
